// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multi-cycle control FSM: opcodes, state encodings,
// ALU/PC mux codes and the datapath control bundle.
package multicycle_control_pkg;

  localparam int OPC_W_DEF = 6;
  localparam int ST_W_DEF  = 4;

  localparam logic [OPC_W_DEF-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W_DEF-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W_DEF-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W_DEF-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W_DEF-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W_DEF-1:0] OP_J     = 6'b000010;

  typedef enum logic [ST_W_DEF-1:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational state -> datapath control decoder (Moore outputs, except the
// FETCH PC/IR strobes which are qualified by memory-ready). Macro: ILLEGAL_OP_TRAP_EN.
module multicycle_control_decode
  import multicycle_control_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic   trap
`endif
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    ctrl = '0;
`ifdef ILLEGAL_OP_TRAP_EN
    trap = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // One PC increment per fetch: strobe only on the cycle memory delivers.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP: trap = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM sequencing the shared ALU/regfile/memory datapath.
// Macro ILLEGAL_OP_TRAP_EN adds o_trap and a sticky TRAP state for unknown opcodes.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPC_W = OPC_W_DEF,
  parameter int ST_W  = ST_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_memReady,
  output logic             o_PCWrite,
  output logic             o_PCWriteCond,
  output logic             o_IorD,
  output logic             o_memRead,
  output logic             o_memWrite,
  output logic             o_IRWrite,
  output logic             o_memToReg,
  output logic             o_regWrite,
  output logic             o_regDst,
  output logic             o_ALUSrcA,
  output logic [1:0]       o_ALUSrcB,
  output logic [1:0]       o_ALUop,
  output logic [1:0]       o_PCSource,
  output logic [ST_W-1:0]  o_state
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic             o_trap
`endif
);

  state_t state, state_next;
  ctrl_t  ctrl;

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge i_clk or negedge i_rst_) begin
    if (!i_rst_) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: if (i_memReady) state_next = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_next = S_TRAP;
`else
          // Unknown opcode retires as a NOP; PC already advanced in FETCH.
          default:      state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: state_next = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (i_memReady) state_next = S_MEMWB;
      S_MEMWR:  if (i_memReady) state_next = S_FETCH;
      S_EXEC:   state_next = S_RWB;
      S_ADDIEX: state_next = S_ADDIWB;
      S_MEMWB, S_RWB, S_BRANCH, S_ADDIWB, S_JUMP: state_next = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:   state_next = S_TRAP;
`endif
      default:  state_next = S_IDLE;
    endcase
  end

  multicycle_control_decode u_decode (
    .state     (state),
    .mem_ready (i_memReady),
    .ctrl      (ctrl)
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    .trap      (o_trap)
`endif
  );

  assign o_PCWrite     = ctrl.pc_write;
  assign o_PCWriteCond = ctrl.pc_write_cond;
  assign o_IorD        = ctrl.i_or_d;
  assign o_memRead     = ctrl.mem_read;
  assign o_memWrite    = ctrl.mem_write;
  assign o_IRWrite     = ctrl.ir_write;
  assign o_memToReg    = ctrl.mem_to_reg;
  assign o_regWrite    = ctrl.reg_write;
  assign o_regDst      = ctrl.reg_dst;
  assign o_ALUSrcA     = ctrl.alu_src_a;
  assign o_ALUSrcB     = ctrl.alu_src_b;
  assign o_ALUop       = ctrl.alu_op;
  assign o_PCSource    = ctrl.pc_source;
  assign o_state       = state;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM that sequences the single shared ALU/register-file/memory datapath of the simple processor across FETCH/DECODE/EXECUTE/MEM/WRITEBACK steps.
- Replaces the combinational control unit when the datapath runs multi-cycle.
- Decodes the 6-bit opcode and stalls on a memory-ready handshake.
- Emits Moore-style datapath enables; PC/IR write strobes are qualified by memory-ready.

Parameters:
- OPC_W, 6, opcode width
- ST_W, 4, state register width (also width of o_state)

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_  input  1  reset, asynchronous, active-low
- i_opcode  input  6  opcode field of instruction register
- i_memReady  input  1  memory completed current access this cycle
- o_PCWrite  output  1  unconditional PC load
- o_PCWriteCond  output  1  PC load if datapath zero flag set (beq)
- o_IorD  output  1  memory address source: 0 = PC, 1 = ALUOut
- o_memRead  output  1  memory read request
- o_memWrite  output  1  memory write request
- o_IRWrite  output  1  instruction register load
- o_memToReg  output  1  register write-data source: 1 = MDR, 0 = ALUOut
- o_regWrite  output  1  register file write enable
- o_regDst  output  1  destination register: 1 = rd, 0 = rt
- o_ALUSrcA  output  1  ALU A source: 0 = PC, 1 = reg A
- o_ALUSrcB  output  2  ALU B source: 00 = reg B, 01 = const 4, 10 = sext imm, 11 = sext imm<<2
- o_ALUop  output  2  00 = add, 01 = sub, 10 = use funct
- o_PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- o_state  output  4  current state, for debug/trace

Behaviour:
- Reset: i_rst_ low asynchronously forces state IDLE; all outputs 0. Reset mid-instruction abandons it with no further strobes.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12, TRAP=13.
- IDLE -> FETCH on the first rising edge after reset release.
- FETCH: memRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00. IRWrite and PCWrite equal i_memReady. Hold in FETCH while i_memReady=0, so PC is incremented exactly once per fetch. Go to DECODE when ready.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target precompute). Next state by opcode:
  - 100011 lw / 101011 sw -> MEMADR
  - 000000 R-type -> EXEC
  - 000100 beq -> BRANCH
  - 001000 addi -> ADDIEX
  - 000010 j -> JUMP
  - other -> see Optional Feature
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: memRead=1, IorD=1. Hold until i_memReady, then MEMWB.
- MEMWB: regWrite=1, memToReg=1, regDst=0. Then FETCH.
- MEMWR: memWrite=1, IorD=1. Hold until i_memReady, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10. Then RWB.
- RWB: regWrite=1, regDst=1, memToReg=0. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01. Then FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUop=00. Then ADDIWB.
- ADDIWB: regWrite=1, regDst=0, memToReg=0. Then FETCH.
- JUMP: PCWrite=1, PCSource=10. Then FETCH.
- Signals not listed for a state are 0.
- memRead and memWrite are never both 1. Requests stay asserted and stable while waiting for i_memReady.
- i_opcode is sampled only in DECODE and MEMADR; the IR is stable there because IRWrite is 0.
- Instruction latency with zero wait states:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
  - each wait cycle adds 1
- i_memReady outside FETCH/MEMRD/MEMWR is ignored.

Optional Feature:
- Macro ILLEGAL_OP_TRAP_EN.
- Defined: an unknown opcode in DECODE -> TRAP. TRAP asserts extra output o_trap=1, drives all other outputs 0 and holds until reset. o_trap resets to 0.
- Undefined: port o_trap absent; an unknown opcode in DECODE -> FETCH, executing as a NOP (PC already advanced).

Decomposition:
- Shared package/include file holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - state encodings
  - ALUop, ALUSrcB and PCSource codes
- The combinational control unit and the ALU control decoder reuse the same constants.
- One natural sub-module: multicycle_control_decode, the combinational state -> output decoder. The FSM register and next-state logic stay in the top module.

Test Plan:
- Reset: assert i_rst_=0 mid-MEMRD -> state=0 and all outputs 0 immediately, with no clock edge needed. Release -> state 1 after one edge.
- R-type (opcode 000000), i_memReady=1 -> states 1,2,7,8,1. regWrite=1 and regDst=1 in state 8 only. PCWrite pulses once.
- lw (100011) with i_memReady low for 3 FETCH cycles and 2 MEMRD cycles -> FETCH held 4 cycles with PCWrite/IRWrite high only in the last one. Full sequence 1,2,3,4,5,1; memRead stable while waiting.
- sw (101011) -> states 1,2,3,6,1. memWrite=1 and IorD=1 in state 6; regWrite never asserted.
- beq (000100) -> 1,2,9,1 with PCWriteCond=1, ALUop=01, PCSource=01 in state 9. j (000010) -> 1,2,12,1 with PCWrite=1, PCSource=10.
- Opcode 111111 -> with ILLEGAL_OP_TRAP_EN: state 13, o_trap=1, held for 10 cycles until reset. Without it: 1,2,1 and no regWrite/memWrite.
